pal_testcard_checker: RTL and testbench

//  Receive-side checker for the PAL 576i RGB111 testcard: takes pixel coordinates
//  and returned RGB111 pixels, regenerates the expected card, compares per pixel.

---
 rtl/pal_testcard_checker.sv | 184 ++++++++++++++++++
 tb/tb_pal_testcard_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_testcard_checker.sv
// Receive-side checker for the PAL 576i RGB111 testcard: regenerates the card and counts per-pixel mismatches per frame.
// Latency: frame_done and the frame results appear together LATENCY+2 clks after the (719,575) coordinate is presented.
// Backpressure: none; pix_ce qualifies coordinates and every qualified sample is consumed.
module pal_testcard_checker #(
    parameter int LATENCY   = 1,
    parameter int ERR_CNT_W = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 pix_ce,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic [2:0]           rgb_111,
    output logic                 frame_done,
    output logic                 frame_pass,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic                 first_err_valid,
    output logic [9:0]           first_err_x,
    output logic [9:0]           first_err_y,
    output logic [15:0]          frames_checked,
    output logic [15:0]          frames_failed
);
    typedef struct packed {
        logic       ce;
        logic [9:0] x;
        logic [9:0] y;
    } coord_t;

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    coord_t               dly_q [LATENCY];
    coord_t               smp;
    logic [2:0]           exp_rgb;
    logic                 in_frame, mism, at_first, at_last;
    state_t               state_q, state_d;
    logic [ERR_CNT_W-1:0] acc_q, acc_d;
    logic                 found_q, found_d;
    logic [9:0]           ex_q, ex_d, ey_q, ey_d;
    logic                 do_zero, do_start, do_accum;

    // Coordinates are delayed so they line up with the returned pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) dly_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < LATENCY; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {pix_ce, pixel_x, pixel_y};
            for (int i = 1; i < LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign smp = dly_q[LATENCY-1];

    // Top half: eight 90-pixel colour bars; bottom half: 20-pixel white grid on black.
    always_comb begin
        exp_rgb = 3'b000;
        if (smp.y < 10'd288) begin
            if (smp.x < 10'd720) exp_rgb = 3'(smp.x / 10'd90);
        end else if (smp.y < 10'd576) begin
            if ((smp.x % 10'd20 == 10'd0) || (smp.y % 10'd20 == 10'd0)) exp_rgb = 3'b111;
        end
    end

    assign in_frame = smp.ce && (smp.x < 10'd720) && (smp.y < 10'd576);
    assign mism     = in_frame && (rgb_111 != exp_rgb);
    assign at_first = (smp.x == 10'd0) && (smp.y == 10'd0);
    assign at_last  = (smp.x == 10'd719) && (smp.y == 10'd575);

    always_comb begin
        state_d  = state_q;
        do_zero  = 1'b0;
        do_start = 1'b0;
        do_accum = 1'b0;
        case (state_q)
            IDLE: begin
                do_zero = 1'b1;
                if (enable && in_frame && at_first) begin
                    state_d  = CHECK;
                    do_start = 1'b1;
                end
            end
            CHECK: begin
                if (!enable) begin
                    state_d = IDLE;
                    do_zero = 1'b1;
                end else if (in_frame) begin
                    if (at_first) begin
                        do_start = 1'b1;
                    end else begin
                        do_accum = 1'b1;
                        if (at_last) state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                // A sample landing here already belongs to the next frame.
                do_zero = 1'b1;
                if (enable) begin
                    state_d = CHECK;
                    if (in_frame && !at_last) do_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        acc_d   = acc_q;
        found_d = found_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        if (do_zero) begin
            acc_d   = '0;
            found_d = 1'b0;
            ex_d    = '0;
            ey_d    = '0;
        end
        if (do_start) begin
            acc_d   = ERR_CNT_W'(mism);
            found_d = mism;
            ex_d    = mism ? smp.x : 10'd0;
            ey_d    = mism ? smp.y : 10'd0;
        end else if (do_accum && mism) begin
            if (acc_q != '1) acc_d = acc_q + ERR_CNT_W'(1);
            if (!found_q) begin
                found_d = 1'b1;
                ex_d    = smp.x;
                ey_d    = smp.y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            found_q         <= 1'b0;
            ex_q            <= '0;
            ey_q            <= '0;
            frame_done      <= 1'b0;
            frame_pass      <= 1'b0;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_x     <= '0;
            first_err_y     <= '0;
            frames_checked  <= '0;
            frames_failed   <= '0;
        end else if (clear) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            found_q         <= 1'b0;
            ex_q            <= '0;
            ey_q            <= '0;
            frame_done      <= 1'b0;
            frame_pass      <= 1'b0;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_x     <= '0;
            first_err_y     <= '0;
            frames_checked  <= '0;
            frames_failed   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            found_q    <= found_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            frame_done <= (state_q == REPORT);
            if (state_q == REPORT) begin
                error_count     <= acc_q;
                frame_pass      <= (acc_q == '0);
                first_err_valid <= found_q;
                first_err_x     <= ex_q;
                first_err_y     <= ey_q;
                frames_checked  <= frames_checked + 16'd1;
                if ((acc_q != '0) && (frames_failed != 16'hFFFF))
                    frames_failed <= frames_failed + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pal_testcard_checker.sv
// Bench for pal_testcard_checker: sparse randomized frames scored against a queue-based model of the testcard.
module tb_pal_testcard_checker;
    logic        clk = 1'b0;
    logic        reset_n, clear, enable, pix_ce;
    logic [9:0]  pixel_x, pixel_y;
    logic [2:0]  gen_rgb;
    logic [2:0]  rgb_pipe [8];
    int          dly3_sel;
    logic [2:0]  rgb1, rgb3;

    logic        fd1, fp1, fv1, fd3, fp3, fv3;
    logic [19:0] ec1, ec3;
    logic [9:0]  fx1, fy1, fx3, fy3;
    logic [15:0] fc1, ff1, fc3, ff3;

    int n_vec = 0, n_bad = 0;
    int done1 = 0, done3 = 0;
    int exp_chk = 0, exp_fail = 0;
    int qx[$], qy[$];
    logic [2:0] qg[$];

    always #5 clk = ~clk;

    // Returned-pixel path: generator output delayed by whole clocks.
    always @(posedge clk) begin
        rgb_pipe[0] <= gen_rgb;
        for (int i = 1; i < 8; i++) rgb_pipe[i] <= rgb_pipe[i-1];
    end
    assign rgb1 = rgb_pipe[0];
    assign rgb3 = rgb_pipe[dly3_sel-1];

    always @(negedge clk) begin
        if (fd1) done1++;
        if (fd3) done3++;
    end

    pal_testcard_checker #(.LATENCY(1), .ERR_CNT_W(20)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .pix_ce(pix_ce),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb_111(rgb1),
        .frame_done(fd1), .frame_pass(fp1), .error_count(ec1), .first_err_valid(fv1),
        .first_err_x(fx1), .first_err_y(fy1), .frames_checked(fc1), .frames_failed(ff1)
    );

    pal_testcard_checker #(.LATENCY(3), .ERR_CNT_W(20)) dut3 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .pix_ce(pix_ce),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb_111(rgb3),
        .frame_done(fd3), .frame_pass(fp3), .error_count(ec3), .first_err_valid(fv3),
        .first_err_x(fx3), .first_err_y(fy3), .frames_checked(fc3), .frames_failed(ff3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    function automatic logic [2:0] ref_pix(input int x, input int y);
        if (x >= 720 || y >= 576) return 3'b000;
        if (y < 288) return 3'(x / 90);
        return ((x % 20 == 0) || (y % 20 == 0)) ? 3'b111 : 3'b000;
    endfunction

    // mode 0: faithful, 1: stuck white, 3: random corruption
    function automatic logic [2:0] gen_for(input int mode, input int x, input int y);
        case (mode)
            1:       return 3'b111;
            3:       return ($urandom_range(0, 5) == 0) ? (ref_pix(x, y) ^ 3'($urandom_range(1, 7)))
                                                        : ref_pix(x, y);
            default: return ref_pix(x, y);
        endcase
    endfunction

    task automatic push(input int x, input int y, input logic [2:0] g);
        qx.push_back(x);
        qy.push_back(y);
        qg.push_back(g);
    endtask

    task automatic push_m(input int mode, input int x, input int y);
        push(x, y, gen_for(mode, x, y));
    endtask

    task automatic qclear();
        qx.delete();
        qy.delete();
        qg.delete();
    endtask

    task automatic build_body(input int mode, input bit forced);
        push_m(mode, 0, 0);
        if (forced) push(100, 10, 3'b000);
        for (int x = 85; x <= 95; x++) push_m(mode, x, 5);
        for (int x = 715; x <= 725; x++) push_m(mode, x, 150);
        for (int x = 178; x <= 182; x++) push_m(mode, x, 300);
        for (int y = 298; y <= 302; y++) push_m(mode, 7, y);
        for (int i = 0; i < 40; i++) begin
            int x, y;
            x = $urandom_range(0, 799);
            y = $urandom_range(1, 639);
            if (x == 719 && y == 575) y = 574;
            push_m(mode, x, y);
        end
        if (forced) push(5, 300, 3'b000);
    endtask

    // Scores the frame starting at the last (0,0); sh models a pixel path sh clocks too short.
    task automatic score(input int sh, output int errs, output int fv, output int fx, output int fy);
        int st;
        logic [2:0] g;
        st = 0; errs = 0; fv = 0; fx = 0; fy = 0;
        for (int i = 0; i < qx.size(); i++) if (qx[i] == 0 && qy[i] == 0) st = i;
        for (int i = st; i < qx.size(); i++) begin
            g = (i + sh < qx.size()) ? qg[i+sh] : 3'b000;
            if (qx[i] < 720 && qy[i] < 576 && g != ref_pix(qx[i], qy[i])) begin
                if (errs == 0) begin
                    fv = 1; fx = qx[i]; fy = qy[i];
                end
                errs++;
            end
        end
    endtask

    task automatic drive(input logic ce, input int x, input int y, input logic [2:0] g);
        @(posedge clk);
        #1;
        pix_ce  = ce;
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        gen_rgb = g;
    endtask

    task automatic send_queue();
        foreach (qx[i]) drive(1'b1, qx[i], qy[i], qg[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 3'b000);
    endtask

    task automatic check_report(input string tag);
        int errs, fv, fx, fy;
        score(0, errs, fv, fx, fy);
        exp_chk++;
        if (errs != 0) exp_fail++;
        check({tag, "_errs"},  ec1, errs);
        check({tag, "_pass"},  fp1, (errs == 0));
        check({tag, "_fvld"},  fv1, fv);
        check({tag, "_fx"},    fx1, fx);
        check({tag, "_fy"},    fy1, fy);
        check({tag, "_nchk"},  fc1, exp_chk);
        check({tag, "_nfail"}, ff1, exp_fail);
    endtask

    initial begin
        int d1, d3, errs, fv, fx, fy;
        reset_n = 1'b0; clear = 1'b0; enable = 1'b1; pix_ce = 1'b0;
        pixel_x = '0; pixel_y = '0; gen_rgb = '0; dly3_sel = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", fd1, 0);
        check("rst_pass", fp1, 0);
        check("rst_errs", ec1, 0);
        check("rst_fvld", fv1, 0);
        check("rst_nchk", fc1, 0);
        check("rst_nfail", ff1, 0);
        check("rst_nchk3", fc3, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // Two good frames, second starting right behind the first.
        d1 = done1; d3 = done3;
        qclear(); build_body(0, 0); push_m(0, 719, 575); build_body(0, 0); push_m(0, 719, 575);
        send_queue(); idle(10);
        check("t1_done", done1, d1 + 2);
        exp_chk++;
        check_report("t1");
        check("t1_pass_c", fp1, 1);
        check("t1_done3", done3, d3 + 2);
        check("t1_pass3", fp3, 1);
        check("t1_nchk3", fc3, 2);

        // Two forced black pixels.
        d1 = done1;
        qclear(); build_body(0, 1); push_m(0, 719, 575);
        send_queue(); idle(10);
        check("t2_done", done1, d1 + 1);
        check("t2_errs_c", ec1, 2);
        check("t2_fx_c", fx1, 100);
        check("t2_fy_c", fy1, 10);
        check_report("t2");

        // Stuck-white frame.
        qclear(); build_body(1, 0); push_m(1, 719, 575);
        send_queue(); idle(10);
        check("t3_pass_c", fp1, 0);
        check_report("t3");

        // Enable drop at y=200: rest of that frame must not report.
        d1 = done1; d3 = done3;
        qclear(); build_body(1, 0); push_m(1, 300, 200);
        send_queue();
        enable = 1'b0; idle(4); enable = 1'b1;
        qclear();
        for (int i = 0; i < 10; i++) push_m(1, $urandom_range(0, 719), $urandom_range(201, 575));
        push_m(1, 719, 575);
        send_queue(); idle(10);
        check("t4_nodone", done1, d1);
        check("t4_nodone3", done3, d3);
        qclear(); build_body(3, 0); push_m(3, 719, 575);
        send_queue(); idle(10);
        check("t4_done", done1, d1 + 1);
        check_report("t4");

        // Frame restart: partial bad frame, then (0,0) begins a fresh one.
        d1 = done1;
        qclear(); build_body(1, 0); build_body(3, 0); push_m(3, 719, 575);
        send_queue(); idle(10);
        check("t4b_done", done1, d1 + 1);
        check_report("t4b");

        // clear coincident with the final sample at the compare stage.
        d1 = done1; d3 = done3;
        qclear(); build_body(0, 0); push_m(0, 719, 575);
        send_queue();
        @(posedge clk); #1;
        pix_ce = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        idle(10);
        exp_chk = 0; exp_fail = 0;
        check("t5_nodone", done1, d1);
        check("t5_nodone3", done3, d3);
        check("t5_nchk", fc1, 0);
        check("t5_nfail", ff1, 0);
        check("t5_errs", ec1, 0);
        check("t5_fvld", fv1, 0);
        check("t5_fx", fx1, 0);
        check("t5_nchk3", fc3, 0);

        // LATENCY=3 checker fed a 2-clk pixel path: bar edges must fail.
        dly3_sel = 2;
        d3 = done3;
        qclear(); build_body(0, 0); push_m(0, 719, 575);
        send_queue(); idle(10);
        score(1, errs, fv, fx, fy);
        check("t6_done3", done3, d3 + 1);
        check("t6_pass3", fp3, 0);
        check("t6_errs3", ec3, errs);
        check_report("t6");
        dly3_sel = 3;
        qclear(); build_body(3, 0); push_m(3, 719, 575);
        send_queue(); idle(10);
        score(0, errs, fv, fx, fy);
        check("t6b_errs3", ec3, errs);
        check("t6b_fx3", fx3, fx);
        check("t6b_nchk3", fc3, 2);
        check_report("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
